// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, defaults and state encoding for the address trace cache
// Ports: none (package).
package cache_pkg;

  localparam int ADDR_W           = 11;
  localparam int INDEX_BITS_DEF   = 4;
  localparam int OFFSET_BITS_DEF  = 2;
  localparam int MISS_PENALTY_DEF = 4;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int CNT_W            = 32;
  localparam int DROP_W           = 16;
  localparam int PEN_W            = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

endpackage

// File: rtl/addr_fifo.sv
// rtl/addr_fifo.sv - pending-address queue with same-cycle push and pop allowed when full
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the queue)
//   push, push_data   enqueue request and data
//   pop               dequeue request (head advances)
//   head              oldest entry, meaningful while empty is low
//   full, empty       occupancy flags
module addr_fifo
  import cache_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign head    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/addr_trace_cache.sv
// rtl/addr_trace_cache.sv - direct-mapped tag cache model replaying a CPU address trace
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   addr_valid, address      trace input, no backpressure
//   hit, miss, lookup_addr   registered one-cycle lookup result and its address
//   busy                     high while a refill is in progress
//   hit_count, miss_count    saturating lookup totals
//   drop_count               saturating count of addresses lost on a full queue
module addr_trace_cache
  import cache_pkg::*;
#(
  parameter int INDEX_BITS   = INDEX_BITS_DEF,
  parameter int OFFSET_BITS  = OFFSET_BITS_DEF,
  parameter int MISS_PENALTY = MISS_PENALTY_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_valid,
  input  logic [ADDR_W-1:0] address,
  output logic              hit,
  output logic              miss,
  output logic [ADDR_W-1:0] lookup_addr,
  output logic              busy,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [DROP_W-1:0] drop_count
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  state_e             state_q;
  logic [PEN_W-1:0]   pen_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_mem_q [LINES];
  logic [INDEX_BITS-1:0] fill_idx_q;
  logic [TAG_W-1:0]   fill_tag_q;
  logic               hit_q, miss_q;
  logic [ADDR_W-1:0]  lookup_addr_q;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;
  logic [CNT_W-1:0]   miss_count_q, miss_count_d;
  logic [DROP_W-1:0]  drop_count_q, drop_count_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W-1:0]  fifo_head;
  logic               in_idle, lk_valid, lk_hit, drop;
  logic [ADDR_W-1:0]  lk_addr;
  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               fill_done;

  addr_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (address),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    // Queued addresses are older than the live input, so they go first.
    lk_valid  = in_idle && (!fifo_empty || addr_valid);
    lk_addr   = fifo_empty ? address : fifo_head;
    lk_idx    = lk_addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    lk_tag    = lk_addr[ADDR_W-1:INDEX_BITS+OFFSET_BITS];
    lk_hit    = valid_q[lk_idx] && (tag_mem_q[lk_idx] == lk_tag);
    fifo_pop  = in_idle && !fifo_empty;
    // While idle the live input only queues behind older entries; during refill it
    // queues if there is room.
    fifo_push = addr_valid && (in_idle ? !fifo_empty : !fifo_full);
    drop      = !in_idle && addr_valid && fifo_full;
    fill_done = (state_q == ST_REFILL) && (pen_q == '0);

    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    drop_count_d = drop_count_q;
    if (lk_valid && lk_hit && (hit_count_q != '1))   hit_count_d  = hit_count_q + CNT_W'(1);
    if (lk_valid && !lk_hit && (miss_count_q != '1)) miss_count_d = miss_count_q + CNT_W'(1);
    if (drop && (drop_count_q != '1))                drop_count_d = drop_count_q + DROP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pen_q         <= '0;
      valid_q       <= '0;
      fill_idx_q    <= '0;
      fill_tag_q    <= '0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      lookup_addr_q <= '0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
      drop_count_q  <= '0;
    end else begin
      hit_q        <= lk_valid && lk_hit;
      miss_q       <= lk_valid && !lk_hit;
      if (lk_valid) lookup_addr_q <= lk_addr;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      drop_count_q <= drop_count_d;
      case (state_q)
        ST_IDLE: begin
          if (lk_valid && !lk_hit) begin
            fill_idx_q <= lk_idx;
            fill_tag_q <= lk_tag;
            pen_q      <= PEN_W'(MISS_PENALTY - 1);
            state_q    <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (pen_q == '0) begin
            valid_q[fill_idx_q] <= 1'b1;
            state_q             <= ST_IDLE;
          end else begin
            pen_q <= pen_q - PEN_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Tags are qualified by valid_q, so this array carries no reset.
  always_ff @(posedge clk) begin
    if (fill_done && !rst) tag_mem_q[fill_idx_q] <= fill_tag_q;
  end

  assign hit         = hit_q;
  assign miss        = miss_q;
  assign lookup_addr = lookup_addr_q;
  assign busy        = (state_q == ST_REFILL);
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_addr_trace_cache.sv
// tb/tb_addr_trace_cache.sv - directed table-driven bench for addr_trace_cache
module tb_addr_trace_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        av;
  logic [10:0] address;

  logic        hit, miss, busy;
  logic [10:0] la;
  logic [31:0] hcnt, mcnt;
  logic [15:0] dcnt;

  logic        hit8, miss8, busy8;
  logic [10:0] la8;
  logic [31:0] hcnt8, mcnt8;
  logic [15:0] dcnt8;

  always #5 clk = ~clk;

  addr_trace_cache dut (
    .clk(clk), .rst(rst), .addr_valid(av), .address(address),
    .hit(hit), .miss(miss), .lookup_addr(la), .busy(busy),
    .hit_count(hcnt), .miss_count(mcnt), .drop_count(dcnt)
  );

  addr_trace_cache #(.MISS_PENALTY(8)) dut8 (
    .clk(clk), .rst(rst), .addr_valid(av), .address(address),
    .hit(hit8), .miss(miss8), .lookup_addr(la8), .busy(busy8),
    .hit_count(hcnt8), .miss_count(mcnt8), .drop_count(dcnt8)
  );

  typedef struct {
    logic        r;
    logic        a;
    logic [10:0] ad;
    logic        h;
    logic        m;
    logic [10:0] la;
    logic        b;
    int          hs;
    int          ms;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic a, input logic [10:0] ad,
                              input logic h, input logic m, input logic [10:0] l,
                              input logic b, input int hs, input int ms);
    vec_t v;
    v.r = r; v.a = a; v.ad = ad; v.h = h; v.m = m; v.la = l; v.b = b; v.hs = hs; v.ms = ms;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic r, input logic a, input logic [10:0] ad);
    @(negedge clk);
    rst = r; av = a; address = ad;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] ovf [6];
    rst = 1'b1; av = 1'b0; address = '0;

    //   rst av  addr    hit miss la     busy hits misses
    add(1, 0, 11'h000, 0, 0, 11'h000, 0, 0, 0);
    // cold miss, 4 busy cycles, then same-line hit
    add(0, 1, 11'h000, 0, 1, 11'h000, 1, 0, 1);
    add(0, 0, 11'h000, 0, 0, 11'h000, 1, 0, 1);
    add(0, 0, 11'h000, 0, 0, 11'h000, 1, 0, 1);
    add(0, 0, 11'h000, 0, 0, 11'h000, 1, 0, 1);
    add(0, 0, 11'h000, 0, 0, 11'h000, 0, 0, 1);
    add(0, 1, 11'h001, 1, 0, 11'h001, 0, 1, 1);
    // miss on 0x010 with three same-line addresses queued behind it
    add(0, 1, 11'h010, 0, 1, 11'h010, 1, 1, 2);
    add(0, 1, 11'h011, 0, 0, 11'h000, 1, 1, 2);
    add(0, 1, 11'h012, 0, 0, 11'h000, 1, 1, 2);
    add(0, 1, 11'h013, 0, 0, 11'h000, 1, 1, 2);
    add(0, 0, 11'h000, 0, 0, 11'h000, 0, 1, 2);
    add(0, 0, 11'h000, 1, 0, 11'h011, 0, 2, 2);
    add(0, 0, 11'h000, 1, 0, 11'h012, 0, 3, 2);
    add(0, 0, 11'h000, 1, 0, 11'h013, 0, 4, 2);
    // conflict: 0x000 / 0x040 / 0x000 share index 0
    add(1, 0, 11'h000, 0, 0, 11'h000, 0, 0, 0);
    add(0, 1, 11'h000, 0, 1, 11'h000, 1, 0, 1);
    add(0, 0, 11'h000, 0, 0, 11'h000, 1, 0, 1);
    add(0, 0, 11'h000, 0, 0, 11'h000, 1, 0, 1);
    add(0, 0, 11'h000, 0, 0, 11'h000, 1, 0, 1);
    add(0, 0, 11'h000, 0, 0, 11'h000, 0, 0, 1);
    add(0, 1, 11'h040, 0, 1, 11'h040, 1, 0, 2);
    add(0, 0, 11'h000, 0, 0, 11'h000, 1, 0, 2);
    add(0, 0, 11'h000, 0, 0, 11'h000, 1, 0, 2);
    add(0, 0, 11'h000, 0, 0, 11'h000, 1, 0, 2);
    add(0, 0, 11'h000, 0, 0, 11'h000, 0, 0, 2);
    add(0, 1, 11'h000, 0, 1, 11'h000, 1, 0, 3);
    add(0, 0, 11'h000, 0, 0, 11'h000, 1, 0, 3);
    add(0, 0, 11'h000, 0, 0, 11'h000, 1, 0, 3);
    add(0, 0, 11'h000, 0, 0, 11'h000, 1, 0, 3);
    add(0, 0, 11'h000, 0, 0, 11'h000, 0, 0, 3);
    // reset in the second refill cycle, then the same address misses again
    add(0, 1, 11'h040, 0, 1, 11'h040, 1, 0, 4);
    add(0, 0, 11'h000, 0, 0, 11'h000, 1, 0, 4);
    add(1, 0, 11'h000, 0, 0, 11'h000, 0, 0, 0);
    add(0, 1, 11'h040, 0, 1, 11'h040, 1, 0, 1);
    // queued address must vanish with a reset during refill
    add(0, 1, 11'h044, 0, 0, 11'h000, 1, 0, 1);
    add(1, 0, 11'h000, 0, 0, 11'h000, 0, 0, 0);
    add(0, 0, 11'h000, 0, 0, 11'h000, 0, 0, 0);
    add(0, 0, 11'h000, 0, 0, 11'h000, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].a, tbl[i].ad);
      chk($sformatf("row%0d hit", i),  {31'd0, hit},  {31'd0, tbl[i].h});
      chk($sformatf("row%0d miss", i), {31'd0, miss}, {31'd0, tbl[i].m});
      chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].b});
      if (tbl[i].h || tbl[i].m || tbl[i].r)
        chk($sformatf("row%0d lookup_addr", i), {21'd0, la}, {21'd0, tbl[i].la});
      chk($sformatf("row%0d hit_count", i),  hcnt, tbl[i].hs);
      chk($sformatf("row%0d miss_count", i), mcnt, tbl[i].ms);
      chk($sformatf("row%0d drop_count", i), {16'd0, dcnt}, 32'd0);
    end

    // Overflow: one miss then six back-to-back addresses on the same line.
    ovf[0] = 11'h081; ovf[1] = 11'h082; ovf[2] = 11'h083;
    ovf[3] = 11'h080; ovf[4] = 11'h081; ovf[5] = 11'h082;
    step(1'b1, 1'b0, 11'h000);
    step(1'b0, 1'b1, 11'h080);
    chk("ovf miss p4", {31'd0, miss},  32'd1);
    chk("ovf miss p8", {31'd0, miss8}, 32'd1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, ovf[k]);
    repeat (30) step(1'b0, 1'b0, 11'h000);
    chk("ovf drop p4", {16'd0, dcnt},  32'd0);
    chk("ovf drop p8", {16'd0, dcnt8}, 32'd2);
    chk("ovf hits p4", hcnt,  32'd6);
    chk("ovf hits p8", hcnt8, 32'd4);
    chk("ovf miss_count p4", mcnt,  32'd1);
    chk("ovf miss_count p8", mcnt8, 32'd1);
    chk("ovf busy p8", {31'd0, busy8}, 32'd0);

    // Saturation: preload the hit total at all-ones, then hit once more.
    @(negedge clk);
    force dut.hit_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.hit_count_q;
    step(1'b0, 1'b1, 11'h080);
    chk("sat hit pulse", {31'd0, hit}, 32'd1);
    chk("sat hit_count", hcnt, 32'hFFFF_FFFF);
    chk("sat hit_count p8", hcnt8, 32'd5);
    step(1'b0, 1'b0, 11'h000);
    chk("sat hold", hcnt, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
